// File: rtl/curam_pkg.sv
// curam_pkg: shared sample-RAM widths, depth and word/address types
package curam_pkg;
  localparam int CURAM_DATA_W = 25;
  localparam int CURAM_ADDR_W = 7;
  localparam int CURAM_DEPTH  = 100;
  typedef logic [CURAM_DATA_W-1:0] curam_word_t;
  typedef logic [CURAM_ADDR_W-1:0] curam_addr_t;
endpackage

// File: rtl/curam_ptr_wrap.sv
// curam_ptr_wrap: modulo-DEPTH pointer (clk, rst_n async, clr sync clear, inc advance, ptr value)
module curam_ptr_wrap
  import curam_pkg::*;
#(
  parameter int ADDR_W = CURAM_ADDR_W,
  parameter int DEPTH  = CURAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/curam_ring_ctrl.sv
// curam_ring_ctrl: circular FIFO over the sample RAM (producer in_*, consumer out_*, RAM ram_*, status count/almost_full/overflow)
module curam_ring_ctrl
  import curam_pkg::*;
#(
  parameter int DATA_W   = CURAM_DATA_W,
  parameter int ADDR_W   = CURAM_ADDR_W,
  parameter int DEPTH    = CURAM_DEPTH,
  parameter int AFULL_TH = 90
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_add,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_read_add,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [ADDR_W-1:0] count,
  output logic              almost_full,
  output logic              overflow
);
  logic              push, fetch, full;
  logic [ADDR_W-1:0] count_nxt;
  always_comb begin
    full        = count == ADDR_W'(DEPTH);
    in_ready    = !full && !flush;
    push        = in_valid && in_ready;
    fetch       = (count != '0) && (!out_valid || out_ready) && !flush;
    count_nxt   = flush ? '0 : count + ADDR_W'(push) - ADDR_W'(fetch);
    ram_wr_en   = push;
    ram_wr_data = in_data;
    ram_rd_en   = fetch;
    out_data    = ram_read_data;
  end
  curam_ptr_wrap #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .clr(flush), .inc(push), .ptr(ram_wr_add)
  );
  curam_ptr_wrap #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .clr(flush), .inc(fetch), .ptr(ram_read_add)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count       <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_nxt;
      out_valid   <= !flush && (fetch || (out_valid && !out_ready));
      overflow    <= !flush && (overflow || (in_valid && full));
      almost_full <= count_nxt >= ADDR_W'(AFULL_TH);
    end
endmodule

// File: doc/curam_ring_ctrl.md
Name: curam_ring_ctrl

Overview:
- Controller that runs the 100-entry x 25-bit sample RAM as a circular FIFO between the echo-sample producer and the downstream distance-processing consumer.
- Generates all RAM write/read strobes and addresses.
- Hides the RAM's 1-cycle registered read latency behind a valid/ready output stage.
- Reports occupancy, almost-full and sticky overflow status to the system controller.

Parameters:
- DATA_W, 25, sample width (matches RAM word).
- ADDR_W, 7, RAM address width.
- DEPTH, 100, usable RAM entries; valid addresses 0..DEPTH-1; DEPTH <= 2**ADDR_W.
- AFULL_TH, 90, occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of pointers, count, output stage and overflow flag.
- in_valid  in  1  producer has a sample.
- in_data  in  DATA_W  producer sample.
- in_ready  out  1  controller accepts a sample this cycle.
- out_valid  out  1  out_data holds an unconsumed sample.
- out_data  out  DATA_W  oldest sample; wired directly from ram_read_data.
- out_ready  in  1  consumer takes out_data.
- ram_wr_en  out  1  RAM write strobe.
- ram_wr_add  out  ADDR_W  RAM write address.
- ram_wr_data  out  DATA_W  RAM write data.
- ram_rd_en  out  1  RAM read strobe.
- ram_read_add  out  ADDR_W  RAM read address.
- ram_read_data  in  DATA_W  RAM registered read data (valid the cycle after ram_rd_en).
- count  out  ADDR_W  entries stored in RAM and not yet fetched.
- almost_full  out  1  count >= AFULL_TH.
- overflow  out  1  sticky: push attempted while full.

Behaviour:
- Reset (rst_n low, async):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - out_valid = 0, overflow = 0.
  - in_ready = 1, almost_full = 0, all RAM strobes = 0.
- Push:
  - in_ready = (count < DEPTH) && !flush (combinational).
  - push = in_valid && in_ready.
  - ram_wr_en = push; ram_wr_add = wr_ptr; ram_wr_data = in_data (combinational).
  - On push, wr_ptr advances; wraps 99 -> 0, never indexes 100..127.
- Fetch:
  - slot_free = !out_valid || out_ready.
  - fetch = (count > 0) && slot_free && !flush.
  - ram_rd_en = fetch; ram_read_add = rd_ptr (combinational).
  - On fetch, rd_ptr advances with the same 99 -> 0 wrap.
- Output stage:
  - Next out_valid = fetch ? 1 : (out_ready ? 0 : out_valid).
  - out_data is valid in the cycle after fetch and holds while out_valid && !out_ready, because the RAM holds read data when rd_en is low.
  - Back-to-back pops sustain 1 sample/cycle.
  - First-word latency: push at cycle N -> out_valid at N+2.
- Count:
  - +1 on push only; -1 on fetch only; unchanged on both or neither.
  - Range 0..DEPTH.
  - The held output word does not occupy count, because its RAM address is no longer needed.
- Simultaneous push and fetch:
  - With count == 0: no fetch; the word becomes readable next cycle.
  - With count == DEPTH: in_ready = 0 that cycle even if a fetch occurs. This is a deliberate registered-full policy, so there is no ready-from-fetch combinational path.
- No read/write address collision:
  - A fetch only targets an entry written in an earlier cycle.
- Overflow:
  - Set when in_valid && count == DEPTH && !flush.
  - Cleared only by reset or flush.
- almost_full is registered from next-count and updates with count.
- Flush:
  - Next cycle: pointers = 0, count = 0, out_valid = 0, overflow = 0.
  - During the flush cycle no RAM strobes are issued and in_ready = 0.
  - RAM contents are not cleared.
- Reset mid-transfer: an asserted rst_n low drops out_valid immediately. Any in-flight sample is lost.

Decomposition:
- Shared package curam_pkg:
  - CURAM_DATA_W = 25, CURAM_ADDR_W = 7, CURAM_DEPTH = 100.
  - Typedef curam_word_t (logic [24:0]) and curam_addr_t (logic [6:0]).
  - Shared with the RAM and the other RAM clients.
- One natural sub-module: curam_ptr_wrap, a modulo-DEPTH pointer with inc and clr inputs, instantiated for wr_ptr and rd_ptr.

Test Plan:
- Reset then idle:
  - Required: in_ready = 1, out_valid = 0, count = 0, no ram_wr_en/ram_rd_en.
  - Push 0x0000001..0x0000003 with out_ready = 0: ram_wr_add 0, 1, 2; count = 2 after fetch of word 0; out_valid = 1 holding 0x0000001.
- Streaming: push 0x1000000 + i for i = 0..199 with out_ready = 1 continuously.
  - Output order identical.
  - Steady-state 1 word/cycle.
  - ram_wr_add and ram_read_add wrap 99 -> 0 twice; never exceed 99.
- Fill to full with out_ready = 0:
  - After 101 pushes (100 in RAM + 1 held): count = 100, in_ready = 0, almost_full = 1.
  - Extra in_valid pulse -> overflow = 1 and stays set.
  - Pop one -> in_ready returns next cycle.
- Backpressure: toggle out_ready randomly for 50 pushed words.
  - out_data stable while out_valid && !out_ready.
  - No word lost or duplicated.
- Flush with count = 40 and out_valid = 1:
  - Next cycle: count = 0, out_valid = 0, overflow = 0, pointers = 0.
  - A following push of 0x0ABCDEF appears at ram_wr_add 0 and is output first.
- Async reset asserted mid-stream between clock edges:
  - Outputs go to reset values immediately.
  - After release, behaves as a fresh FIFO starting at address 0.
